// File: rtl/jtkicker_sdram_arb_pkg.sv
// Shared types for the Kicker SDRAM read arbiter: FSM states, client slot ids
// and the 22-bit word-address helper.
package jtkicker_sdram_arb_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SNAP_W   = 15;   // widest client address (main, byte addressed)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_REQ2,
        ST_WAIT2
    } arb_state_e;

    typedef enum logic [1:0] {
        SLOT_MAIN = 2'd0,
        SLOT_OBJ  = 2'd1,
        SLOT_SCR  = 2'd2
    } slot_id_e;

    // Region offset plus relative word address, wrapping modulo 2^22.
    function automatic logic [SDRAM_AW-1:0] word_addr(
        input logic [SDRAM_AW-1:0] offset,
        input logic [SDRAM_AW-1:0] rel
    );
        return offset + rel;
    endfunction

endpackage

// File: rtl/jtkicker_arb_slot.sv
// One-entry read cache for a single ROM client: tag/valid/data, hit compare,
// ok generation and masked fill so multi-word clients can fill in halves.
module jtkicker_arb_slot #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          fill_i,
    input  logic [DW-1:0] fill_mask_i,
    input  logic [DW-1:0] fill_data_i,
    input  logic          commit_i,
    input  logic [AW-1:0] tag_i,
    output logic          ok_o,
    output logic          miss_o,
    output logic [DW-1:0] dout_o
);

    logic [AW-1:0] tag_q;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          hit;

    assign hit    = valid_q && (addr_i == tag_q);
    assign ok_o   = cs_i && hit && !clr_i;
    assign miss_o = cs_i && !hit;
    assign dout_o = data_q;

    // NOTE: the data word is a handful of flops, not a RAM, so it is reset
    // along with tag/valid and dout reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            data_q <= (data_q & ~fill_mask_i) | (fill_data_i & fill_mask_i);
            // A partial fill invalidates the entry so a stale tag never
            // returns a half-overwritten word.
            valid_q <= commit_i;
            if (commit_i) tag_q <= tag_i;
        end
    end

endmodule

// File: rtl/jtkicker_sdram_arb.sv
// Fixed-priority (main > obj > scr) SDRAM read arbiter with a one-entry cache
// per client; objects need two consecutive SDRAM words per 32-bit read.
module jtkicker_sdram_arb
    import jtkicker_sdram_arb_pkg::*;
#(
    parameter logic [21:0] SCR_OFFSET  = 22'h0,
    parameter logic [21:0] OBJ_OFFSET  = 22'h0,
    parameter logic [21:0] MAIN_OFFSET = 22'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        main_cs,
    input  logic [14:0] main_addr,
    output logic        main_ok,
    output logic [7:0]  main_dout,
    input  logic        scr_cs,
    input  logic [11:0] scr_addr,
    output logic        scr_ok,
    output logic [15:0] scr_dout,
    input  logic        obj_cs,
    input  logic [11:0] obj_addr,
    output logic        obj_ok,
    output logic [31:0] obj_dout,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [15:0] data_read
);

    arb_state_e          state_q;
    slot_id_e            win_q;
    logic [SNAP_W-1:0]   snap_q;
    logic                req_q;
    logic [SDRAM_AW-1:0] addr_q;

    logic                main_miss, obj_miss, scr_miss;
    slot_id_e            sel_id;
    logic [SNAP_W-1:0]   sel_snap;
    logic [SDRAM_AW-1:0] sel_addr;
    logic                rdy_wait, rdy_wait2;
    logic                fill_main, fill_scr, fill_obj_lo, fill_obj_hi;

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sel_id   = SLOT_MAIN;
        sel_snap = main_addr;
        sel_addr = word_addr(MAIN_OFFSET, {8'd0, main_addr[14:1]});
        if (!main_miss && obj_miss) begin
            sel_id   = SLOT_OBJ;
            sel_snap = {3'd0, obj_addr};
            sel_addr = word_addr(OBJ_OFFSET, {9'd0, obj_addr, 1'b0});
        end else if (!main_miss && scr_miss) begin
            sel_id   = SLOT_SCR;
            sel_snap = {3'd0, scr_addr};
            sel_addr = word_addr(SCR_OFFSET, {10'd0, scr_addr});
        end
    end

    assign rdy_wait    = (state_q == ST_WAIT)  && data_rdy && !downloading;
    assign rdy_wait2   = (state_q == ST_WAIT2) && data_rdy && !downloading;
    assign fill_main   = rdy_wait && (win_q == SLOT_MAIN);
    assign fill_scr    = rdy_wait && (win_q == SLOT_SCR);
    assign fill_obj_lo = rdy_wait && (win_q == SLOT_OBJ);
    assign fill_obj_hi = rdy_wait2;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= SLOT_MAIN;
            snap_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else if (downloading) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (main_miss || obj_miss || scr_miss) begin
                    win_q   <= sel_id;
                    snap_q  <= sel_snap;
                    addr_q  <= sel_addr;
                    req_q   <= 1'b1;
                    state_q <= ST_REQ;
                end
                ST_REQ: if (sdram_ack) begin
                    req_q   <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: if (data_rdy) begin
                    if (win_q == SLOT_OBJ) begin
                        addr_q  <= addr_q + 22'd1;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ2;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ2: if (sdram_ack) begin
                    req_q   <= 1'b0;
                    state_q <= ST_WAIT2;
                end
                ST_WAIT2: if (data_rdy) state_q <= ST_IDLE;
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    jtkicker_arb_slot #(.AW(15), .DW(8)) u_main (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (downloading),
        .cs_i        (main_cs),
        .addr_i      (main_addr),
        .fill_i      (fill_main),
        .fill_mask_i (8'hFF),
        .fill_data_i (snap_q[0] ? data_read[15:8] : data_read[7:0]),
        .commit_i    (1'b1),
        .tag_i       (snap_q),
        .ok_o        (main_ok),
        .miss_o      (main_miss),
        .dout_o      (main_dout)
    );

    jtkicker_arb_slot #(.AW(12), .DW(32)) u_obj (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (downloading),
        .cs_i        (obj_cs),
        .addr_i      (obj_addr),
        .fill_i      (fill_obj_lo || fill_obj_hi),
        .fill_mask_i (fill_obj_hi ? 32'hFFFF_0000 : 32'h0000_FFFF),
        .fill_data_i ({data_read, data_read}),
        .commit_i    (fill_obj_hi),
        .tag_i       (snap_q[11:0]),
        .ok_o        (obj_ok),
        .miss_o      (obj_miss),
        .dout_o      (obj_dout)
    );

    jtkicker_arb_slot #(.AW(12), .DW(16)) u_scr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (downloading),
        .cs_i        (scr_cs),
        .addr_i      (scr_addr),
        .fill_i      (fill_scr),
        .fill_mask_i (16'hFFFF),
        .fill_data_i (data_read),
        .commit_i    (1'b1),
        .tag_i       (snap_q[11:0]),
        .ok_o        (scr_ok),
        .miss_o      (scr_miss),
        .dout_o      (scr_dout)
    );

endmodule
